// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO offsets, status bit positions and access classification.
// Pure declarations: no latency and no backpressure.
package dmem_pkg;

    localparam logic [7:0] OFS_GPIO_OUT = 8'h00;
    localparam logic [7:0] OFS_GPIO_IN  = 8'h01;
    localparam logic [7:0] OFS_TMR_CNT  = 8'h02;
    localparam logic [7:0] OFS_TMR_CMP  = 8'h03;
    localparam logic [7:0] OFS_TMR_CTRL = 8'h04;
    localparam logic [7:0] OFS_ERR      = 8'h05;

    localparam int ERR_COLL  = 0;
    localparam int ERR_UNMAP = 1;

    localparam int TMR_EN  = 0;
    localparam int TMR_IRQ = 1;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_RD   = 2'd1,
        ACC_WR   = 2'd2,
        ACC_COLL = 2'd3
    } acc_e;

    // Strobes are meaningless without m_en; both strobes together is a collision.
    function automatic acc_e acc_kind(input logic en, input logic rd, input logic wr);
        if (!en)            return ACC_NONE;
        else if (rd && wr)  return ACC_COLL;
        else if (rd)        return ACC_RD;
        else if (wr)        return ACC_WR;
        else                return ACC_NONE;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-memory bus: the CPU drives the master side, the responder sits on the slave side.
// Fixed-latency bus with no handshake, so there is no backpressure.
interface dmem_responder_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              m_en;
    logic              m_rd;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wr_data;
    logic [DATA_W-1:0] m_rd_data;

    modport master (output m_en, m_rd, m_wr, m_addr, m_wr_data, input m_rd_data);
    modport slave  (input m_en, m_rd, m_wr, m_addr, m_wr_data, output m_rd_data);
endinterface

// File: rtl/dmem_timer.sv
// Prescaled compare timer: counter, compare register, enable and sticky compare status (write-1-clear, set wins).
// Register writes take effect at the next edge; no backpressure.
module dmem_timer
    import dmem_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int PRESCALE = 16
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              cmp_we_i,
    input  logic              ctrl_we_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] cnt_o,
    output logic [DATA_W-1:0] cmp_o,
    output logic              en_o,
    output logic              sts_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]     pre_q, pre_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] cmp_q, cmp_d;
    logic              en_q, en_d;
    logic              sts_q, sts_d;
    logic              tick;
    logic              sts_set;

    always_comb begin
        pre_d   = pre_q;
        tick    = 1'b0;
        cnt_d   = cnt_q;
        sts_set = 1'b0;
        // Disabling parks the prescaler so re-enabling always gives a full first period.
        if (!en_q) begin
            pre_d = '0;
        end else if (pre_q == PW'(PRESCALE - 1)) begin
            pre_d = '0;
            tick  = 1'b1;
        end else begin
            pre_d = pre_q + PW'(1);
        end
        if (tick) begin
            if (cnt_q == cmp_q) begin
                cnt_d   = '0;
                sts_set = 1'b1;
            end else begin
                cnt_d = cnt_q + DATA_W'(1);
            end
        end
        cmp_d = cmp_we_i  ? wr_data_i         : cmp_q;
        en_d  = ctrl_we_i ? wr_data_i[TMR_EN] : en_q;
        sts_d = (sts_q & ~(ctrl_we_i & wr_data_i[TMR_IRQ])) | sts_set;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            pre_q <= '0;
            cnt_q <= '0;
            cmp_q <= '0;
            en_q  <= 1'b0;
            sts_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
            cmp_q <= cmp_d;
            en_q  <= en_d;
            sts_q <= sts_d;
        end
    end

    assign cnt_o = cnt_q;
    assign cmp_o = cmp_q;
    assign en_o  = en_q;
    assign sts_o = sts_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: RAM below MMIO_BASE, GPIO/timer/error registers above; reads return one cycle later, writes commit at the edge.
// No wait states or backpressure. Define DMEM_TIMER_EN to include the compare timer; otherwise its offsets decode as unmapped.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int                ADDR_W       = 12,
    parameter int                DATA_W       = 8,
    parameter logic [ADDR_W-1:0] MMIO_BASE    = 12'hF00,
    parameter int                TMR_PRESCALE = 16
) (
    input  logic              clk,
    input  logic              reset_,
    dmem_responder_if.slave   bus,
    input  logic [DATA_W-1:0] gpio_in,
    output logic [DATA_W-1:0] gpio_out,
    output logic              irq,
    output logic              err
);

    acc_e              acc;
    logic              is_mmio;
    logic [ADDR_W-1:0] ofs;
    logic              hit_gpio_out, hit_gpio_in, hit_err;
    logic              hit_cnt, hit_cmp, hit_ctrl;
    logic              unmapped;

    logic [DATA_W-1:0] mem [0:MMIO_BASE-1];
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] gpio_out_q, gpio_out_d;
    logic [DATA_W-1:0] gpio_s1_q, gpio_s2_q;
    logic [1:0]        err_sts_q, err_sts_d;
    logic [1:0]        err_set, err_clr;
    logic              err_q;

    logic [DATA_W-1:0] tmr_cnt, tmr_cmp;
    logic              tmr_en, tmr_sts;

    assign acc     = acc_kind(bus.m_en, bus.m_rd, bus.m_wr);
    assign is_mmio = (bus.m_addr >= MMIO_BASE);
    assign ofs     = bus.m_addr - MMIO_BASE;

    assign hit_gpio_out = is_mmio && (ofs == ADDR_W'(OFS_GPIO_OUT));
    assign hit_gpio_in  = is_mmio && (ofs == ADDR_W'(OFS_GPIO_IN));
    assign hit_err      = is_mmio && (ofs == ADDR_W'(OFS_ERR));

`ifdef DMEM_TIMER_EN
    assign hit_cnt  = is_mmio && (ofs == ADDR_W'(OFS_TMR_CNT));
    assign hit_cmp  = is_mmio && (ofs == ADDR_W'(OFS_TMR_CMP));
    assign hit_ctrl = is_mmio && (ofs == ADDR_W'(OFS_TMR_CTRL));

    dmem_timer #(
        .DATA_W   (DATA_W),
        .PRESCALE (TMR_PRESCALE)
    ) u_timer (
        .clk       (clk),
        .reset_    (reset_),
        .cmp_we_i  ((acc == ACC_WR) && hit_cmp),
        .ctrl_we_i ((acc == ACC_WR) && hit_ctrl),
        .wr_data_i (bus.m_wr_data),
        .cnt_o     (tmr_cnt),
        .cmp_o     (tmr_cmp),
        .en_o      (tmr_en),
        .sts_o     (tmr_sts)
    );
`else
    assign hit_cnt  = 1'b0;
    assign hit_cmp  = 1'b0;
    assign hit_ctrl = 1'b0;
    assign tmr_cnt  = '0;
    assign tmr_cmp  = '0;
    assign tmr_en   = 1'b0;
    assign tmr_sts  = 1'b0;
`endif

    assign unmapped = is_mmio && !(hit_gpio_out || hit_gpio_in || hit_err ||
                                   hit_cnt || hit_cmp || hit_ctrl);

    always_comb begin
        rd_mux = '0;
        if (!is_mmio)          rd_mux = mem[bus.m_addr];
        else if (hit_gpio_out) rd_mux = gpio_out_q;
        else if (hit_gpio_in)  rd_mux = gpio_s2_q;
        else if (hit_cnt)      rd_mux = tmr_cnt;
        else if (hit_cmp)      rd_mux = tmr_cmp;
        else if (hit_ctrl)     rd_mux = DATA_W'({tmr_sts, tmr_en});
        else if (hit_err)      rd_mux = DATA_W'(err_sts_q);
    end

    always_comb begin
        rd_data_d  = (acc == ACC_RD) ? rd_mux : rd_data_q;
        gpio_out_d = ((acc == ACC_WR) && hit_gpio_out) ? bus.m_wr_data : gpio_out_q;

        err_set            = '0;
        err_set[ERR_COLL]  = (acc == ACC_COLL);
        err_set[ERR_UNMAP] = ((acc == ACC_RD) || (acc == ACC_WR)) && unmapped;
        err_clr            = ((acc == ACC_WR) && hit_err) ? bus.m_wr_data[1:0] : 2'b00;
        err_sts_d          = (err_sts_q & ~err_clr) | err_set;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            rd_data_q  <= '0;
            gpio_out_q <= '0;
            gpio_s1_q  <= '0;
            gpio_s2_q  <= '0;
            err_sts_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            gpio_out_q <= gpio_out_d;
            gpio_s1_q  <= gpio_in;
            gpio_s2_q  <= gpio_s1_q;
            err_sts_q  <= err_sts_d;
            err_q      <= |err_sts_d;
        end
    end

    // RAM is not reset, but a write coinciding with reset is still dropped.
    always_ff @(posedge clk) begin
        if (reset_ && (acc == ACC_WR) && !is_mmio) begin
            mem[bus.m_addr] <= bus.m_wr_data;
        end
    end

    assign bus.m_rd_data = rd_data_q;
    assign gpio_out      = gpio_out_q;
    assign irq           = tmr_sts;
    assign err           = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: reads feed an expected-data queue checked by an independent monitor.
// Timer vectors run when DMEM_TIMER_EN is defined; otherwise the timer offsets are checked as unmapped.
module tb_dmem_responder;

    logic       clk;
    logic       reset_;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic       irq;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q  [$];
    logic [11:0] addr_q [$];

    dmem_responder_if bus ();

    dmem_responder dut (
        .clk      (clk),
        .reset_   (reset_),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, expv);
        end
    endtask

    // One bus cycle: drive at the falling edge, let one rising edge sample it, then go idle.
    task automatic drive(input logic rd, input logic wr, input logic [11:0] a, input logic [7:0] d);
        bus.m_en      = 1'b1;
        bus.m_rd      = rd;
        bus.m_wr      = wr;
        bus.m_addr    = a;
        bus.m_wr_data = d;
        @(negedge clk);
        bus.m_en = 1'b0;
        bus.m_rd = 1'b0;
        bus.m_wr = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        drive(1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [11:0] a, input logic [7:0] expv);
        exp_q.push_back(expv);
        addr_q.push_back(a);
        drive(1'b1, 1'b0, a, 8'h00);
    endtask

    task automatic coll(input logic [11:0] a, input logic [7:0] d);
        drive(1'b1, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Monitor: every accepted read produces a response one edge later.
    initial begin
        logic [7:0]  e;
        logic [11:0] a;
        forever begin
            @(posedge clk);
            if (reset_ && bus.m_en && bus.m_rd && !bus.m_wr) begin
                #1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: got 0x%02h, expected no response", bus.m_rd_data);
                end else begin
                    e = exp_q.pop_front();
                    a = addr_q.pop_front();
                    if (bus.m_rd_data !== e) begin
                        errors++;
                        $display("FAIL rd_%03h: got 0x%02h, expected 0x%02h", a, bus.m_rd_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_        = 1'b0;
        gpio_in       = 8'h00;
        bus.m_en      = 1'b0;
        bus.m_rd      = 1'b0;
        bus.m_wr      = 1'b0;
        bus.m_addr    = '0;
        bus.m_wr_data = '0;
        idle(3);
        reset_ = 1'b1;

        check("rst_rd_data", bus.m_rd_data, 8'h00);
        check("rst_gpio_out", gpio_out, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        check("rst_err", {7'b0, err}, 8'h00);

        // RAM write then immediate read-back, data held while idle
        wr(12'h123, 8'hA5);
        rd(12'h123, 8'hA5);
        idle(3);
        check("rd_hold", bus.m_rd_data, 8'hA5);

        // RAM edges
        wr(12'h000, 8'h11);
        wr(12'hEFF, 8'h5A);
        rd(12'h000, 8'h11);
        rd(12'hEFF, 8'h5A);

        // GPIO
        wr(12'hF00, 8'h3C);
        check("gpio_out", gpio_out, 8'h3C);
        rd(12'hF00, 8'h3C);
        gpio_in = 8'h81;
        idle(3);
        rd(12'hF01, 8'h81);

        // Collision: no write, read data held, collision bit set then W1C
        wr(12'h010, 8'h77);
        rd(12'h010, 8'h77);
        coll(12'h010, 8'hFF);
        check("coll_hold", bus.m_rd_data, 8'h77);
        check("coll_err", {7'b0, err}, 8'h01);
        rd(12'hF05, 8'h01);
        wr(12'hF05, 8'h01);
        check("coll_clr", {7'b0, err}, 8'h00);
        rd(12'h010, 8'h77);

        // Write to a read-only register is silently ignored
        wr(12'hF01, 8'hFF);
        check("ro_wr_err", {7'b0, err}, 8'h00);
        rd(12'hF01, 8'h81);
        rd(12'hF05, 8'h00);

        // Unmapped read and write
        rd(12'hF80, 8'h00);
        check("unmap_rd_err", {7'b0, err}, 8'h01);
        rd(12'hF05, 8'h02);
        wr(12'hF05, 8'h02);
        check("unmap_clr", {7'b0, err}, 8'h00);
        wr(12'hFFF, 8'h12);
        check("unmap_wr_err", {7'b0, err}, 8'h01);
        wr(12'hF05, 8'h03);
        check("unmap_wr_clr", {7'b0, err}, 8'h00);

`ifdef DMEM_TIMER_EN
        // Prescale 16, compare 2: count 0,1,2 then wrap with status
        wr(12'hF03, 8'h02);
        rd(12'hF03, 8'h02);
        wr(12'hF04, 8'h01);
        rd(12'hF02, 8'h00);
        idle(15);
        rd(12'hF02, 8'h01);
        idle(15);
        rd(12'hF02, 8'h02);
        idle(14);
        check("irq_before", {7'b0, irq}, 8'h00);
        rd(12'hF02, 8'h02);
        check("irq_set", {7'b0, irq}, 8'h01);
        rd(12'hF02, 8'h00);
        rd(12'hF04, 8'h03);
        wr(12'hF04, 8'h03);
        check("irq_w1c", {7'b0, irq}, 8'h00);
        // Clear lands on the same edge as the next compare tick
        idle(44);
        wr(12'hF04, 8'h03);
        check("irq_set_wins", {7'b0, irq}, 8'h01);
        wr(12'hF04, 8'h02);
        check("irq_dis_clr", {7'b0, irq}, 8'h00);
        rd(12'hF02, 8'h00);
        idle(40);
        rd(12'hF02, 8'h00);
        check("irq_frozen", {7'b0, irq}, 8'h00);
        check("tmr_no_err", {7'b0, err}, 8'h00);
`else
        // Timer offsets decode as unmapped
        rd(12'hF02, 8'h00);
        check("notmr_err", {7'b0, err}, 8'h01);
        rd(12'hF05, 8'h02);
        wr(12'hF05, 8'h02);
        wr(12'hF03, 8'h00);
        wr(12'hF04, 8'h01);
        rd(12'hF04, 8'h00);
        idle(60);
        check("notmr_irq", {7'b0, irq}, 8'h00);
        rd(12'hF05, 8'h02);
        wr(12'hF05, 8'h02);
        check("notmr_clr", {7'b0, err}, 8'h00);
`endif

        // Reset mid-operation drops the coincident write
        wr(12'h020, 8'h44);
        rd(12'hF00, 8'h3C);
        coll(12'h000, 8'h00);
        check("pre_rst_err", {7'b0, err}, 8'h01);
        reset_        = 1'b0;
        bus.m_en      = 1'b1;
        bus.m_wr      = 1'b1;
        bus.m_addr    = 12'h020;
        bus.m_wr_data = 8'h99;
        @(negedge clk);
        reset_   = 1'b1;
        bus.m_en = 1'b0;
        bus.m_wr = 1'b0;
        check("mid_rst_gpio", gpio_out, 8'h00);
        check("mid_rst_rd_data", bus.m_rd_data, 8'h00);
        check("mid_rst_err", {7'b0, err}, 8'h00);
        check("mid_rst_irq", {7'b0, irq}, 8'h00);
        rd(12'h020, 8'h44);
        rd(12'hF00, 8'h00);
        rd(12'h123, 8'hA5);

        idle(3);
        check("rsp_queue_empty", 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
